// File: rtl/call_stack_unit.sv
// ============================================================================
//  Module      : call_stack_unit
//  Description : Parametrised return-address stack. Push on call, pop on
//                return, same-cycle push+pop replaces the top entry.
//                Registered pop data with a one-cycle valid strobe,
//                combinational top-of-stack peek, sticky overflow/underflow
//                flags and a synchronous flush.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module call_stack_unit #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0,
    parameter int CW       = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int            c_PW        = $clog2(DEPTH);
    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);
    localparam bit            c_WRAP      = (OVF_MODE == 1);

    // Storage and state
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_tp;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_pop_data;
    logic             r_pop_valid;
    logic             r_overflow;
    logic             r_underflow;

    // Decoded controls
    logic [c_PW-1:0]  w_top_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_push_only;
    logic             w_pop_only;
    logic             w_both;
    logic             w_mem_we;
    logic [c_PW-1:0]  w_mem_addr;
    logic             w_tp_inc;
    logic             w_tp_dec;
    logic             w_cnt_inc;
    logic             w_cnt_dec;
    logic             w_pop_accept;
    logic             w_pop_bypass;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_top_idx = r_tp - c_PW'(1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH_CNT);

    // Decode the request into array, pointer, counter and flag actions
    always_comb begin
        w_push_only  = push && !pop;
        w_pop_only   = pop && !push;
        w_both       = push && pop;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_tp;
        w_tp_inc     = 1'b0;
        w_tp_dec     = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cnt_dec    = 1'b0;
        w_pop_accept = 1'b0;
        w_pop_bypass = 1'b0;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;

        if (!clear) begin
            if (w_push_only) begin
                // A full stack either drops the push or overwrites the oldest slot
                if (!w_full || c_WRAP) begin
                    w_mem_we = 1'b1;
                    w_tp_inc = 1'b1;
                end
                w_cnt_inc = !w_full;
                w_ovf_set = w_full;
            end else if (w_pop_only) begin
                w_pop_accept = !w_empty;
                w_tp_dec     = !w_empty;
                w_cnt_dec    = !w_empty;
                w_unf_set    = w_empty;
            end else if (w_both) begin
                // Replace the top, or pass the pushed value straight through when empty
                w_pop_accept = 1'b1;
                w_pop_bypass = w_empty;
                w_mem_we     = !w_empty;
                w_mem_addr   = w_top_idx;
            end
        end
    end

    // Entry array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= push_data;
        end
    end

    // Pointer, count, pop output register and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tp        <= '0;
            r_count     <= '0;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_tp        <= '0;
            r_count     <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_tp_inc) begin
                r_tp <= r_tp + c_PW'(1);
            end else if (w_tp_dec) begin
                r_tp <= w_top_idx;
            end

            if (w_cnt_inc) begin
                r_count <= r_count + CW'(1);
            end else if (w_cnt_dec) begin
                r_count <= r_count - CW'(1);
            end

            r_pop_valid <= w_pop_accept;
            if (w_pop_accept) begin
                r_pop_data <= w_pop_bypass ? push_data : r_mem[w_top_idx];
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign top_data  = w_empty ? '0 : r_mem[w_top_idx];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_call_stack_unit.sv
// ============================================================================
//  Module      : tb_call_stack_unit
//  Description : Self-checking bench for call_stack_unit. Two instances
//                (reject and wrap overflow modes) share one stimulus stream
//                and are compared each cycle against list-based models.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_call_stack_unit;

    localparam int c_W = 32;
    localparam int c_D = 8;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        push;
    logic [31:0] push_data;
    logic        pop;

    logic [31:0] pop_data  [2];
    logic        pop_valid [2];
    logic [31:0] top_data  [2];
    logic [3:0]  count     [2];
    logic        empty     [2];
    logic        full      [2];
    logic        overflow  [2];
    logic        underflow [2];

    call_stack_unit #(.WIDTH(c_W), .DEPTH(c_D), .OVF_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .clear(clear), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data[0]), .pop_valid(pop_valid[0]), .top_data(top_data[0]),
        .count(count[0]), .empty(empty[0]), .full(full[0]), .overflow(overflow[0]),
        .underflow(underflow[0])
    );

    call_stack_unit #(.WIDTH(c_W), .DEPTH(c_D), .OVF_MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clear), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pop_data[1]), .pop_valid(pop_valid[1]), .top_data(top_data[1]),
        .count(count[1]), .empty(empty[1]), .full(full[1]), .overflow(overflow[1]),
        .underflow(underflow[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per mode, a list with the oldest entry at index 0 and top at n-1
    logic [31:0] m_stk [2][c_D];
    int          m_n   [2];
    logic [31:0] m_pd  [2];
    logic        m_pv  [2];
    logic        m_ovf [2];
    logic        m_unf [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_n[m]   = 0;
            m_pd[m]  = '0;
            m_pv[m]  = 1'b0;
            m_ovf[m] = 1'b0;
            m_unf[m] = 1'b0;
        end
    endtask

    task automatic model_update(input int m);
        if (clear) begin
            m_n[m]   = 0;
            m_ovf[m] = 1'b0;
            m_unf[m] = 1'b0;
            m_pv[m]  = 1'b0;
        end else if (push && !pop) begin
            m_pv[m] = 1'b0;
            if (m_n[m] < c_D) begin
                m_stk[m][m_n[m]] = push_data;
                m_n[m]++;
            end else begin
                m_ovf[m] = 1'b1;
                if (m == 1) begin
                    for (int i = 0; i < c_D - 1; i++) m_stk[m][i] = m_stk[m][i+1];
                    m_stk[m][c_D-1] = push_data;
                end
            end
        end else if (pop && !push) begin
            if (m_n[m] > 0) begin
                m_n[m]--;
                m_pd[m] = m_stk[m][m_n[m]];
                m_pv[m] = 1'b1;
            end else begin
                m_unf[m] = 1'b1;
                m_pv[m]  = 1'b0;
            end
        end else if (push && pop) begin
            if (m_n[m] > 0) begin
                m_pd[m] = m_stk[m][m_n[m]-1];
                m_stk[m][m_n[m]-1] = push_data;
            end else begin
                m_pd[m] = push_data;
            end
            m_pv[m] = 1'b1;
        end else begin
            m_pv[m] = 1'b0;
        end
    endtask

    // Per-cycle comparison of both instances against their models
    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                check($sformatf("count[%0d]", m), 64'(count[m]), 64'(m_n[m]));
                check($sformatf("top[%0d]", m), 64'(top_data[m]),
                      (m_n[m] > 0) ? 64'(m_stk[m][m_n[m]-1]) : 64'd0);
                check($sformatf("empty[%0d]", m), 64'(empty[m]), 64'(m_n[m] == 0));
                check($sformatf("full[%0d]", m), 64'(full[m]), 64'(m_n[m] == c_D));
                check($sformatf("pop_valid[%0d]", m), 64'(pop_valid[m]), 64'(m_pv[m]));
                check($sformatf("pop_data[%0d]", m), 64'(pop_data[m]), 64'(m_pd[m]));
                check($sformatf("overflow[%0d]", m), 64'(overflow[m]), 64'(m_ovf[m]));
                check($sformatf("underflow[%0d]", m), 64'(underflow[m]), 64'(m_unf[m]));
            end
        end
    end

    // Apply one cycle of stimulus; returns just after the following falling edge
    task automatic step(input logic pu, input logic [31:0] d, input logic po, input logic cl);
        push      = pu;
        push_data = d;
        pop       = po;
        clear     = cl;
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        // Reset state, hand-computed
        check("rst_count", 64'(count[0]), 64'd0);
        check("rst_empty", 64'(empty[0]), 64'd1);
        check("rst_pv", 64'(pop_valid[1]), 64'd0);
        check("rst_pd", 64'(pop_data[0]), 64'd0);
        check("rst_top", 64'(top_data[0]), 64'd0);
        check("rst_flags", 64'({overflow[0], underflow[0]}), 64'd0);
        chk_en = 1'b1;

        // Basic LIFO order
        step(1, 32'h09, 0, 0);
        step(1, 32'h14, 0, 0);
        step(1, 32'h21, 0, 0);
        check("lifo_count", 64'(count[0]), 64'd3);
        check("lifo_top", 64'(top_data[0]), 64'h21);
        step(0, 0, 1, 0);
        check("lifo_pop1", 64'({pop_valid[0], pop_data[0]}), {31'd0, 1'b1, 32'h21});
        step(0, 0, 1, 0);
        check("lifo_pop2", 64'({pop_valid[0], pop_data[0]}), {31'd0, 1'b1, 32'h14});
        step(0, 0, 1, 0);
        check("lifo_pop3", 64'({pop_valid[0], pop_data[0]}), {31'd0, 1'b1, 32'h09});
        check("lifo_empty", 64'(empty[0]), 64'd1);
        check("lifo_top0", 64'(top_data[0]), 64'd0);

        // Overflow: reject (inst 0) vs wrap (inst 1)
        step(0, 0, 0, 1);
        for (int i = 1; i <= 10; i++) step(1, 32'(i), 0, 0);
        check("ovf0_count", 64'(count[0]), 64'd8);
        check("ovf0_flag", 64'(overflow[0]), 64'd1);
        check("ovf1_count", 64'(count[1]), 64'd8);
        check("ovf1_flag", 64'(overflow[1]), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            check("ovf0_pop", 64'(pop_data[0]), 64'(8 - i));
            check("ovf1_pop", 64'(pop_data[1]), 64'(10 - i));
        end
        check("ovf_empty", 64'({empty[0], empty[1]}), 64'd3);

        // Replace-top and empty bypass
        step(0, 0, 0, 1);
        step(1, 32'h05, 0, 0);
        step(1, 32'h07, 1, 0);
        check("rep_pd", 64'({pop_valid[0], pop_data[0]}), {31'd0, 1'b1, 32'h05});
        check("rep_count", 64'(count[0]), 64'd1);
        check("rep_top", 64'(top_data[0]), 64'h07);
        step(0, 0, 0, 1);
        step(1, 32'h33, 1, 0);
        check("byp_pd", 64'(pop_data[0]), 64'h33);
        check("byp_count", 64'(count[0]), 64'd0);
        check("byp_unf", 64'(underflow[0]), 64'd0);

        // Underflow then clear with an ignored push
        step(0, 0, 1, 0);
        check("unf_flag", 64'(underflow[0]), 64'd1);
        check("unf_pv", 64'(pop_valid[0]), 64'd0);
        check("unf_pd", 64'(pop_data[0]), 64'h33);
        step(1, 32'h44, 0, 1);
        check("clr_unf", 64'(underflow[0]), 64'd0);
        check("clr_count", 64'(count[0]), 64'd0);

        // Randomised traffic in three phases: filling, draining, balanced
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 600; c++) begin
                int pu_th;
                pu_th = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
                step(($urandom_range(0, 99) < pu_th), $urandom,
                     ($urandom_range(0, 99) < (100 - pu_th)),
                     ($urandom_range(0, 63) == 0));
            end
        end

        // Asynchronous reset in the middle of a cycle
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(1, 32'h0A, 0, 0);
        step(1, 32'h0B, 0, 0);
        step(0, 0, 1, 0);
        check("pre_rst_pv", 64'(pop_valid[0]), 64'd1);
        chk_en = 1'b0;
        push = 1'b0; pop = 1'b0; clear = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_count", 64'(count[0]), 64'd0);
        check("arst_pv", 64'(pop_valid[0]), 64'd0);
        check("arst_flags", 64'({overflow[0], underflow[0], overflow[1], underflow[1]}), 64'd0);
        check("arst_top", 64'(top_data[1]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        step(0, 0, 1, 0);
        check("post_rst_unf", 64'(underflow[0]), 64'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
